// File: rtl/dwt_dma_pkg.sv
// ---------------------------------------------------------------------------
// dwt_dma_pkg
// Shared definitions for the DWT read and write DMA engines.
//   - AXI burst / response / cache encodings
//   - DMA control FSM state enum
//   - awlen_width(): width of AxLEN for the selected AXI protocol
//     (0 = AXI4, 8-bit AxLEN; 1 = AXI3, 4-bit AxLEN)
// ---------------------------------------------------------------------------
package dwt_dma_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Bufferable + modifiable: lets the interconnect merge/split writes to DDR.
   localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B
   } dma_state_t;

   // AXI3 limits a burst to 16 beats, AXI4 to 256.
   function automatic int awlen_width(input int protocol);
      return (protocol == 1) ? 4 : 8;
   endfunction

endpackage

// File: rtl/dwt_wr_dma.sv
// ---------------------------------------------------------------------------
// dwt_wr_dma
// Single-burst AXI write master. Takes one command (address, beat count,
// beat size), forwards that many words from a valid/ready stream onto the
// AXI W channel as a single INCR burst, then collects the B response.
//
// Ports
//   m_axi_aclk, m_axi_areset        clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only when idle)
//   cmd_addr, cmd_len, cmd_size     burst start address, beats-1, AxSIZE
//   s_data, s_valid, s_ready        input stream
//   m_dst_axi_aw*                   AXI write address channel
//   m_dst_axi_w*                    AXI write data channel
//   m_dst_axi_b*                    AXI write response channel
//   busy                            any state other than idle
//   done                            one-cycle pulse when the response is taken
//   err                             sticky non-OKAY response flag, cleared by
//                                   the next accepted command
// ---------------------------------------------------------------------------
module dwt_wr_dma
   import dwt_dma_pkg::*;
#(
   parameter int DMA_DATA_WIDTH_DST   = 64,
   parameter int DMA_AXI_PROTOCOL_DST = 0,
   parameter int DMA_AXI_ADDR_WIDTH   = 32,
   parameter int C_M_AXI_ID_WIDTH     = 1
) (
   input  logic                                          m_axi_aclk,
   input  logic                                          m_axi_areset,

   input  logic                                          cmd_valid,
   output logic                                          cmd_ready,
   input  logic [DMA_AXI_ADDR_WIDTH-1:0]                 cmd_addr,
   input  logic [7:0]                                    cmd_len,
   input  logic [2:0]                                    cmd_size,

   input  logic [DMA_DATA_WIDTH_DST-1:0]                 s_data,
   input  logic                                          s_valid,
   output logic                                          s_ready,

   output logic [C_M_AXI_ID_WIDTH-1:0]                   m_dst_axi_awid,
   output logic [DMA_AXI_ADDR_WIDTH-1:0]                 m_dst_axi_awaddr,
   output logic [awlen_width(DMA_AXI_PROTOCOL_DST)-1:0]  m_dst_axi_awlen,
   output logic [2:0]                                    m_dst_axi_awsize,
   output logic [1:0]                                    m_dst_axi_awburst,
   output logic                                          m_dst_axi_awlock,
   output logic [3:0]                                    m_dst_axi_awcache,
   output logic [2:0]                                    m_dst_axi_awprot,
   output logic [3:0]                                    m_dst_axi_awqos,
   output logic                                          m_dst_axi_awvalid,
   input  logic                                          m_dst_axi_awready,

   output logic [DMA_DATA_WIDTH_DST-1:0]                 m_dst_axi_wdata,
   output logic [DMA_DATA_WIDTH_DST/8-1:0]               m_dst_axi_wstrb,
   output logic                                          m_dst_axi_wlast,
   output logic                                          m_dst_axi_wvalid,
   input  logic                                          m_dst_axi_wready,

   input  logic [C_M_AXI_ID_WIDTH-1:0]                   m_dst_axi_bid,
   input  logic [1:0]                                    m_dst_axi_bresp,
   input  logic                                          m_dst_axi_bvalid,
   output logic                                          m_dst_axi_bready,

   output logic                                          busy,
   output logic                                          done,
   output logic                                          err
);

   localparam int LEN_W = awlen_width(DMA_AXI_PROTOCOL_DST);

   dma_state_t                    state;
   logic [DMA_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [LEN_W-1:0]              len_q;
   logic [2:0]                    size_q;
   logic [LEN_W-1:0]              beat_cnt;
   logic                          awvalid_q;
   logic                          bready_q;
   logic                          done_q;
   logic                          err_q;
   logic                          in_w;
   logic                          last_beat;
   logic                          unused_bits;

   // Control FSM. The command is captured on accept and the AW fields are
   // served from those registers, so they stay stable while awvalid waits
   // for awready. The beat counter only advances on real W handshakes and is
   // compared against the registered length to mark the final beat. done and
   // bready are registered so they line up exactly with the state they
   // belong to (done high in the first idle cycle, bready from the first
   // response cycle). For AXI3 only the low nibble of cmd_len is kept.
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         beat_cnt  <= '0;
         awvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state     <= ST_AW;
                  addr_q    <= cmd_addr;
                  len_q     <= cmd_len[LEN_W-1:0];
                  size_q    <= cmd_size;
                  beat_cnt  <= '0;
                  awvalid_q <= 1'b1;
                  err_q     <= 1'b0;
               end
            end
            ST_AW: begin
               if (m_dst_axi_awready) begin
                  awvalid_q <= 1'b0;
                  state     <= ST_W;
               end
            end
            ST_W: begin
               if (s_valid && m_dst_axi_wready) begin
                  if (last_beat) begin
                     state    <= ST_B;
                     bready_q <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ST_B: begin
               if (m_dst_axi_bvalid) begin
                  bready_q <= 1'b0;
                  done_q   <= 1'b1;
                  err_q    <= err_q | (m_dst_axi_bresp != AXI_RESP_OKAY);
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The W channel is a straight pass-through of the stream while in the
   // data phase, so no beat can leave before the address handshake and no
   // latency is added. Outside the data phase the stream is back-pressured.
   assign in_w      = (state == ST_W);
   assign last_beat = (beat_cnt == len_q);

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;

   assign s_ready          = in_w & m_dst_axi_wready;
   assign m_dst_axi_wvalid = in_w & s_valid;
   assign m_dst_axi_wdata  = s_data;
   assign m_dst_axi_wlast  = in_w & last_beat;
   assign m_dst_axi_wstrb  = '1;

   assign m_dst_axi_awid    = '0;
   assign m_dst_axi_awaddr  = addr_q;
   assign m_dst_axi_awlen   = len_q;
   assign m_dst_axi_awsize  = size_q;
   assign m_dst_axi_awburst = AXI_BURST_INCR;
   assign m_dst_axi_awlock  = 1'b0;
   assign m_dst_axi_awcache = AXI_CACHE_BUF_MOD;
   assign m_dst_axi_awprot  = 3'b000;
   assign m_dst_axi_awqos   = 4'b0000;
   assign m_dst_axi_awvalid = awvalid_q;
   assign m_dst_axi_bready  = bready_q;

   // Single outstanding burst, so the response ID carries no information;
   // upper cmd_len bits are meaningless under AXI3.
   assign unused_bits = ^{m_dst_axi_bid, cmd_len};

endmodule

// File: tb/tb_dwt_wr_dma.sv
// ---------------------------------------------------------------------------
// tb_dwt_wr_dma
// Self-checking bench for dwt_wr_dma. An AXI4 instance is driven by a
// randomized stream source and AXI slave and compared every cycle against a
// transaction-phase model; an AXI3 instance checks awlen truncation.
// ---------------------------------------------------------------------------
module tb_dwt_wr_dma;

   typedef enum int {P_IDLE, P_AW, P_DATA, P_RESP} phase_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [63:0] s_data;
   logic        s_valid, s_ready;
   logic [0:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic [3:0]  awqos;
   logic        awvalid, awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [0:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic        busy, done, err;

   logic        cmd_valid_3, cmd_ready_3;
   logic [31:0] cmd_addr_3;
   logic [7:0]  cmd_len_3;
   logic [2:0]  cmd_size_3;
   logic [63:0] s_data_3;
   logic        s_valid_3, s_ready_3;
   logic [0:0]  awid_3;
   logic [31:0] awaddr_3;
   logic [3:0]  awlen_3;
   logic [2:0]  awsize_3;
   logic [1:0]  awburst_3;
   logic        awlock_3;
   logic [3:0]  awcache_3;
   logic [2:0]  awprot_3;
   logic [3:0]  awqos_3;
   logic        awvalid_3, awready_3;
   logic [63:0] wdata_3;
   logic [7:0]  wstrb_3;
   logic        wlast_3, wvalid_3, wready_3;
   logic [0:0]  bid_3;
   logic [1:0]  bresp_3;
   logic        bvalid_3, bready_3;
   logic        busy_3, done_3, err_3;

   int errors = 0;
   int checks = 0;

   logic [63:0] src_words [2048];
   int          src_idx = 0;
   bit          s_hs_flag = 1'b0;

   phase_t      phase_m = P_IDLE;
   logic [31:0] addr_m;
   int          len_m;
   logic [2:0]  size_m;
   int          beats_m = 0;
   int          total_m = 0;
   bit          done_exp = 1'b0;
   bit          err_m = 1'b0;
   int          aw_cycles = 0;
   int          resp_cycles = 0;

   bit          stall_en = 1'b0;
   int          aw_delay = 0;
   int          b_delay = 0;
   logic [1:0]  bresp_sel = 2'b00;

   int          done_count = 0;
   int          burst_beats = 0;
   int          burst_wlast = 0;
   bit          last_beat_wlast = 1'b0;

   always #5 clock = ~clock;

   dwt_wr_dma #(
      .DMA_DATA_WIDTH_DST(64), .DMA_AXI_PROTOCOL_DST(0),
      .DMA_AXI_ADDR_WIDTH(32), .C_M_AXI_ID_WIDTH(1)
   ) dut (
      .m_axi_aclk(clock), .m_axi_areset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_dst_axi_awid(awid), .m_dst_axi_awaddr(awaddr), .m_dst_axi_awlen(awlen),
      .m_dst_axi_awsize(awsize), .m_dst_axi_awburst(awburst), .m_dst_axi_awlock(awlock),
      .m_dst_axi_awcache(awcache), .m_dst_axi_awprot(awprot), .m_dst_axi_awqos(awqos),
      .m_dst_axi_awvalid(awvalid), .m_dst_axi_awready(awready),
      .m_dst_axi_wdata(wdata), .m_dst_axi_wstrb(wstrb), .m_dst_axi_wlast(wlast),
      .m_dst_axi_wvalid(wvalid), .m_dst_axi_wready(wready),
      .m_dst_axi_bid(bid), .m_dst_axi_bresp(bresp), .m_dst_axi_bvalid(bvalid),
      .m_dst_axi_bready(bready),
      .busy(busy), .done(done), .err(err)
   );

   dwt_wr_dma #(
      .DMA_DATA_WIDTH_DST(64), .DMA_AXI_PROTOCOL_DST(1),
      .DMA_AXI_ADDR_WIDTH(32), .C_M_AXI_ID_WIDTH(1)
   ) dut_axi3 (
      .m_axi_aclk(clock), .m_axi_areset(reset),
      .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3), .cmd_addr(cmd_addr_3),
      .cmd_len(cmd_len_3), .cmd_size(cmd_size_3),
      .s_data(s_data_3), .s_valid(s_valid_3), .s_ready(s_ready_3),
      .m_dst_axi_awid(awid_3), .m_dst_axi_awaddr(awaddr_3), .m_dst_axi_awlen(awlen_3),
      .m_dst_axi_awsize(awsize_3), .m_dst_axi_awburst(awburst_3), .m_dst_axi_awlock(awlock_3),
      .m_dst_axi_awcache(awcache_3), .m_dst_axi_awprot(awprot_3), .m_dst_axi_awqos(awqos_3),
      .m_dst_axi_awvalid(awvalid_3), .m_dst_axi_awready(awready_3),
      .m_dst_axi_wdata(wdata_3), .m_dst_axi_wstrb(wstrb_3), .m_dst_axi_wlast(wlast_3),
      .m_dst_axi_wvalid(wvalid_3), .m_dst_axi_wready(wready_3),
      .m_dst_axi_bid(bid_3), .m_dst_axi_bresp(bresp_3), .m_dst_axi_bvalid(bvalid_3),
      .m_dst_axi_bready(bready_3),
      .busy(busy_3), .done(done_3), .err(err_3)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Stream source and AXI slave behaviour, applied just after each rising
   // edge. The source keeps valid and data steady until a word is taken.
   task automatic applyStimulus();
      if (!(s_valid && !s_hs_flag))
         s_valid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = src_words[src_idx % 2048];
      awready = (phase_m == P_AW) && (aw_cycles >= aw_delay);
      wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      bvalid  = (phase_m == P_RESP) && (resp_cycles >= b_delay);
      bresp   = bresp_sel;
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         applyStimulus();
      end
   end

   // Compare process: on every falling edge the outputs are checked against
   // what the current transaction phase demands, then the model advances on
   // the handshakes that the coming rising edge will complete.
   always @(negedge clock) begin
      if (reset) begin
         phase_m     = P_IDLE;
         done_exp    = 1'b0;
         err_m       = 1'b0;
         beats_m     = 0;
         total_m     = src_idx;
         aw_cycles   = 0;
         resp_cycles = 0;
         s_hs_flag   = 1'b0;
      end else begin
         checkOutput("cmd_ready", cmd_ready, phase_m == P_IDLE);
         checkOutput("busy", busy, phase_m != P_IDLE);
         checkOutput("done", done, done_exp);
         checkOutput("err", err, err_m);
         checkOutput("awvalid", awvalid, phase_m == P_AW);
         if (phase_m == P_AW) begin
            checkOutput("awaddr", awaddr, addr_m);
            checkOutput("awlen", awlen, len_m);
            checkOutput("awsize", awsize, size_m);
            checkOutput("aw_consts", {awid, awburst, awlock, awcache, awprot, awqos},
                        {1'b0, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
         end
         checkOutput("wvalid", wvalid, (phase_m == P_DATA) && s_valid);
         checkOutput("s_ready", s_ready, (phase_m == P_DATA) && wready);
         if (phase_m == P_DATA && s_valid) begin
            checkOutput("wdata", wdata, src_words[total_m % 2048]);
            checkOutput("wlast", wlast, beats_m == len_m);
            checkOutput("wstrb", wstrb, 8'hFF);
         end
         checkOutput("bready", bready, phase_m == P_RESP);

         if (done) done_count++;
         if (wvalid && wready) begin
            burst_beats++;
            last_beat_wlast = wlast;
            if (wlast) burst_wlast++;
         end
         s_hs_flag = s_valid && s_ready;
         if (s_hs_flag) src_idx++;

         done_exp = 1'b0;
         case (phase_m)
            P_IDLE: if (cmd_valid) begin
               phase_m   = P_AW;
               addr_m    = cmd_addr;
               len_m     = int'(cmd_len);
               size_m    = cmd_size;
               err_m     = 1'b0;
               beats_m   = 0;
               aw_cycles = 0;
            end
            P_AW: begin
               aw_cycles++;
               if (awready) phase_m = P_DATA;
            end
            P_DATA: if (s_valid && wready) begin
               total_m++;
               beats_m++;
               if (beats_m == len_m + 1) begin
                  phase_m     = P_RESP;
                  resp_cycles = 0;
               end
            end
            P_RESP: begin
               resp_cycles++;
               if (bvalid) begin
                  phase_m  = P_IDLE;
                  done_exp = 1'b1;
                  err_m    = err_m | (bresp != 2'b00);
               end
            end
            default: phase_m = P_IDLE;
         endcase
      end
   end

   // Issues one command on the AXI4 instance and waits, with a cycle budget,
   // for its done pulse.
   task automatic runBurst(input logic [31:0] a, input int len, input logic [2:0] sz,
                           input bit stall, input int awd, input int bd, input logic [1:0] resp);
      int start;
      int n;
      stall_en        = stall;
      aw_delay        = awd;
      b_delay         = bd;
      bresp_sel       = resp;
      burst_beats     = 0;
      burst_wlast     = 0;
      last_beat_wlast = 1'b0;
      start           = done_count;
      @(posedge clock);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = 8'(len);
      cmd_size  = sz;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!cmd_ready && n < 100);
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      n = 0;
      while (done_count == start && n < 6000) begin
         @(posedge clock);
         n++;
      end
      #1;
      checkOutput("done_within_budget", n < 6000, 1'b1);
   endtask

   initial begin
      int len_r;
      int n;
      int beats3;
      int last_at;
      bit done3_seen;
      bit accepted;
      logic [3:0] awlen_seen;

      for (int i = 0; i < 2048; i++) src_words[i] = {$urandom, $urandom};
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
      s_valid = 1'b0; s_data = '0; awready = 1'b0; wready = 1'b0;
      bid = '0; bresp = '0; bvalid = 1'b0;
      cmd_valid_3 = 1'b0; cmd_addr_3 = '0; cmd_len_3 = '0; cmd_size_3 = '0;
      s_valid_3 = 1'b0; s_data_3 = '0; awready_3 = 1'b0; wready_3 = 1'b0;
      bid_3 = '0; bresp_3 = '0; bvalid_3 = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_awvalid", awvalid, 1'b0);
      checkOutput("rst_wvalid", wvalid, 1'b0);
      checkOutput("rst_bready", bready, 1'b0);
      checkOutput("rst_busy_done_err", {busy, done, err}, 3'b000);
      reset = 1'b0;
      #1;
      checkOutput("post_rst_cmd_ready", cmd_ready, 1'b1);

      $display("[TB] full 256-beat burst, no stalls");
      runBurst(32'h0000_1000, 255, 3'd3, 1'b0, 0, 0, 2'b00);
      checkOutput("t1_beats", burst_beats, 256);
      checkOutput("t1_wlast_count", burst_wlast, 1);
      checkOutput("t1_last_has_wlast", last_beat_wlast, 1'b1);
      checkOutput("t1_err", err, 1'b0);

      $display("[TB] 256-beat burst with random stalls");
      runBurst(32'h0000_1000, 255, 3'd3, 1'b1, 2, 3, 2'b00);
      checkOutput("t2_beats", burst_beats, 256);
      checkOutput("t2_wlast_count", burst_wlast, 1);

      $display("[TB] single beat, delayed awready");
      runBurst(32'h0000_2000, 0, 3'd3, 1'b1, 5, 1, 2'b00);
      checkOutput("t3_beats", burst_beats, 1);
      checkOutput("t3_last_has_wlast", last_beat_wlast, 1'b1);

      $display("[TB] SLVERR response");
      runBurst(32'h0000_3000, 3, 3'd2, 1'b0, 0, 2, 2'b10);
      checkOutput("t4_err_set", err, 1'b1);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("t4_err_sticky", err, 1'b1);
      runBurst(32'h0000_3100, 1, 3'd3, 1'b0, 0, 0, 2'b00);
      checkOutput("t4_err_cleared", err, 1'b0);
      checkOutput("t4_beats", burst_beats, 2);

      $display("[TB] random bursts");
      for (int k = 0; k < 8; k++) begin
         len_r = $urandom_range(0, 31);
         runBurst(32'($urandom_range(0, 1023)) << 12, len_r, 3'($urandom_range(0, 3)),
                  1'b1, $urandom_range(0, 3), $urandom_range(0, 4),
                  ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
         checkOutput("rand_beats", burst_beats, len_r + 1);
      end

      $display("[TB] reset in the middle of the data phase");
      stall_en = 1'b0; aw_delay = 0; b_delay = 0; bresp_sel = 2'b00;
      burst_beats = 0;
      @(posedge clock);
      #1;
      cmd_valid = 1'b1; cmd_addr = 32'h0000_4000; cmd_len = 8'd255; cmd_size = 3'd3;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      n = 0;
      while (burst_beats < 100 && n < 1000) begin
         @(posedge clock);
         n++;
      end
      checkOutput("t5_reached_beat_100", n < 1000, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t5_awvalid", awvalid, 1'b0);
      checkOutput("t5_wvalid", wvalid, 1'b0);
      checkOutput("t5_bready", bready, 1'b0);
      checkOutput("t5_busy_done", {busy, done}, 2'b00);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("t5_cmd_ready_after", cmd_ready, 1'b1);
      runBurst(32'h0000_5000, 7, 3'd3, 1'b1, 1, 1, 2'b00);
      checkOutput("t5_recover_beats", burst_beats, 8);

      $display("[TB] AXI3 awlen truncation");
      s_valid_3 = 1'b1; awready_3 = 1'b1; wready_3 = 1'b1; bvalid_3 = 1'b1; bresp_3 = 2'b00;
      s_data_3 = 64'h1234;
      @(posedge clock);
      #1;
      cmd_valid_3 = 1'b1; cmd_addr_3 = 32'h0000_6000; cmd_len_3 = 8'h1F; cmd_size_3 = 3'd3;
      n = 0; beats3 = 0; last_at = 0; done3_seen = 1'b0; accepted = 1'b0; awlen_seen = '0;
      while (!done3_seen && n < 300) begin
         @(negedge clock);
         n++;
         if (cmd_valid_3 && cmd_ready_3) accepted = 1'b1;
         if (awvalid_3 && awready_3) awlen_seen = awlen_3;
         if (wvalid_3 && wready_3) begin
            beats3++;
            if (wlast_3) last_at = beats3;
         end
         if (done_3) done3_seen = 1'b1;
         @(posedge clock);
         #1;
         if (accepted) cmd_valid_3 = 1'b0;
      end
      checkOutput("t6_done", done3_seen, 1'b1);
      checkOutput("t6_awlen", awlen_seen, 4'hF);
      checkOutput("t6_beats", beats3, 16);
      checkOutput("t6_wlast_beat", last_at, 16);

      repeat (2) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
